// File: rtl/rs232_tx_ctrl_pkg.sv
// Shared constants and elaboration-time helpers for the RS-232 transmitter.
// Holds the clock-generator constants and the ceil-log2 helper used by the bit timer.
package rs232_tx_ctrl_pkg;

  localparam int CLKMUL       = 1;
  localparam int CLKDIV       = 1;
  localparam int CLKIN_PERIOD = 20;

  localparam int DATA_W = 8;

  // Core clock in Hz: the input period in ns scaled by the clock generator ratio.
  localparam longint CLK_HZ = (longint'(1000000000) * longint'(CLKMUL)) /
                              (longint'(CLKDIV) * longint'(CLKIN_PERIOD));

  function automatic int log2x(input longint n);
    int     r;
    longint v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int clocks_per_bit(input longint baud);
    longint num;
    longint den;
    num = longint'(1000000000) * longint'(CLKMUL);
    den = baud * longint'(CLKDIV) * longint'(CLKIN_PERIOD);
    return int'(num / den);
  endfunction

endpackage

// File: rtl/rs232_tx_fifo.sv
// Byte buffer between the host handshake and the serialiser.
// Pushes while full and pops while empty are ignored; pointers wrap modulo DEPTH.
module rs232_tx_fifo
  import rs232_tx_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rs232_tx_ctrl.sv
// RS-232 8N1 transmitter: buffers bytes from a valid/ready handshake and
// serialises them LSB first with one start and one stop bit.
module rs232_tx_ctrl
  import rs232_tx_ctrl_pkg::*;
#(
`ifdef MODEL_TECH
  parameter int BAUD       = int'(CLK_HZ / 4),
`else
  parameter int BAUD       = 9600,
`endif
  parameter int FIFO_DEPTH = 4,
  parameter int NOISY      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       val,
  input  logic [7:0] bits,
  output logic       rdy,
  output logic       busy,
  output logic       TxD
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int CLOCKS_PER_BIT          = clocks_per_bit(longint'(BAUD));
  localparam int CNT_W                   = log2x(longint'(CLOCKS_PER_BIT));
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              bit_end;

  // Byte tracing is a simulation-only concern and has no hardware footprint.
  logic noisy_unused;
  assign noisy_unused = (NOISY != 0);

  assign rdy     = !fifo_full;
  assign push    = val && rdy;
  assign bit_end = (cnt == CNT_LAST);

  rs232_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (bits),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end && (bit_idx == 3'd7)) state_next = STOP;
      end
      STOP: begin
        // Chain straight into the next frame when more data is waiting.
        if (bit_end) begin
          if (!fifo_empty) begin
            state_next = START;
            pop        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      TxD     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      // The line follows the current state, so every bit is delayed uniformly by one cycle.
      unique case (state)
        START:   TxD <= 1'b0;
        DATA:    TxD <= shreg[0];
        default: TxD <= 1'b1;
      endcase

      busy <= !((state == IDLE) && fifo_empty);

      if (state_next != state) begin
        cnt     <= '0;
        bit_idx <= '0;
      end else if (state != IDLE) begin
        cnt <= bit_end ? '0 : cnt + 1'b1;
        if ((state == DATA) && bit_end) bit_idx <= bit_idx + 1'b1;
      end

      if (pop) shreg <= fifo_dout;
      else if ((state == DATA) && bit_end) shreg <= {1'b0, shreg[7:1]};
    end
  end

endmodule

// File: tb/tb_rs232_tx_ctrl.sv
// Self-checking bench for rs232_tx_ctrl at four clocks per bit: accepted bytes
// go into a scoreboard queue and a serial receiver model pops and compares them.
module tb_rs232_tx_ctrl;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       val  = 1'b0;
  logic [7:0] bits = 8'h00;
  logic       rdy;
  logic       busy;
  logic       TxD;

  int checks      = 0;
  int failures    = 0;
  int cycle_cnt   = 0;
  int frames_seen = 0;

  logic [7:0] exp_q[$];
  int         frame_starts[$];
  int         exp_off[6] = '{0, 1, 2, 3, 4, 42};

  rs232_tx_ctrl #(
    .BAUD      (12_500_000),
    .FIFO_DEPTH(4),
    .NOISY     (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .val (val),
    .bits(bits),
    .rdy (rdy),
    .busy(busy),
    .TxD (TxD)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, actual, expected, cycle_cnt);
    end
  endtask

  function automatic logic frameBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return d[idx-1];
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic applyStimulus(input logic [7:0] b, input int max_wait, output int acc_cyc);
    logic taken;
    taken   = 1'b0;
    acc_cyc = -1;
    val     = 1'b1;
    bits    = b;
    for (int w = 0; w < max_wait && !taken; w++) begin
      #1;
      taken = (rdy === 1'b1) && (rst === 1'b1);
      if (taken) exp_q.push_back(b);
      @(negedge clk);
    end
    val = 1'b0;
    if (taken) acc_cyc = cycle_cnt;
    checkOutput("accepted", taken, 1'b1);
  endtask

  task automatic waitIdle(input int max_cycles);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy !== 1'b0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", n < max_cycles, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  // Receiver model: samples mid-bit, abandons any frame cut by reset.
  initial begin : rx_model
    logic [9:0] fb;
    logic       ok;
    int         st;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && TxD === 1'b0) begin
        ok = 1'b1;
        st = cycle_cnt;
        fb = '0;
        for (int j = 0; j < FRAME; j++) begin
          if (j > 0) @(negedge clk);
          if (rst !== 1'b1) ok = 1'b0;
          if (j % CPB == CPB / 2) fb[j/CPB] = TxD;
        end
        if (ok) begin
          frames_seen++;
          frame_starts.push_back(st);
          checkOutput("rx_start_bit", fb[0], 1'b0);
          checkOutput("rx_stop_bit", fb[9], 1'b1);
          checkOutput("rx_frame_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) checkOutput("rx_byte", fb[8:1], exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int a;
    int e0;
    int rel;
    int bad_cnt;
    int frames_before;
    int acc[$];

    #2 rst = 1'b0;
    #1;
    checkOutput("reset_txd", TxD, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_rdy", rdy, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] single byte 0x55 timing");
    applyStimulus(8'h55, 4, a);
    checkOutput("busy_at_accept", busy, 1'b0);
    @(negedge clk);
    checkOutput("txd_before_start", TxD, 1'b1);
    checkOutput("busy_after_accept", busy, 1'b1);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      checkOutput("frame55_txd", TxD, frameBit(8'h55, k / CPB));
    end
    checkOutput("busy_last_stop", busy, 1'b1);
    @(negedge clk);
    checkOutput("busy_fall", busy, 1'b0);
    checkOutput("idle_txd", TxD, 1'b1);
    checkOutput("start_latency", frame_starts[frame_starts.size()-1], a + 2);

    $display("[TB] held val, bytes 0x00..0x05, then discarded pulse");
    frame_starts.delete();
    frames_seen = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i[7:0], 100, a);
      acc.push_back(a);
    end
    for (int i = 0; i < 6; i++) checkOutput("accept_offset", acc[i] - acc[0], exp_off[i]);
    checkOutput("rdy_full", rdy, 1'b0);
    val  = 1'b1;
    bits = 8'hEE;
    @(negedge clk);
    val = 1'b0;
    waitIdle(600);
    checkOutput("burst_frames", frames_seen, 6);
    checkOutput("burst_first_start", frame_starts[0], acc[0] + 2);
    for (int i = 1; i < frame_starts.size(); i++)
      checkOutput("burst_gap", frame_starts[i] - frame_starts[i-1], FRAME);
    checkOutput("burst_queue_drained", exp_q.size(), 0);

    $display("[TB] push coinciding with stop-bit end");
    frame_starts.delete();
    frames_seen = 0;
    applyStimulus(8'hC1, 4, a);
    e0 = a;
    @(negedge clk);
    applyStimulus(8'h3C, 4, a);
    checkOutput("acc_second", a - e0, 2);
    while (cycle_cnt < e0 + 40) @(negedge clk);
    checkOutput("rdy_before_swap", rdy, 1'b1);
    applyStimulus(8'h96, 4, a);
    checkOutput("acc_swap", a - e0, 41);
    checkOutput("rdy_after_swap", rdy, 1'b1);
    waitIdle(400);
    checkOutput("swap_frames", frames_seen, 3);
    for (int i = 1; i < frame_starts.size(); i++)
      checkOutput("swap_gap", frame_starts[i] - frame_starts[i-1], FRAME);

    $display("[TB] reset in the middle of 0xA3");
    applyStimulus(8'hA3, 4, a);
    while (cycle_cnt < a + 2 + 13) @(negedge clk);
    checkOutput("pre_reset_txd", TxD, frameBit(8'hA3, 3));
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("async_txd", TxD, 1'b1);
    checkOutput("async_busy", busy, 1'b0);
    checkOutput("async_rdy", rdy, 1'b1);
    val  = 1'b1;
    bits = 8'h77;
    repeat (3) @(negedge clk);
    val = 1'b0;
    rst = 1'b1;
    frames_before = frames_seen;
    bad_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (TxD !== 1'b1 || busy !== 1'b0) bad_cnt++;
    end
    checkOutput("post_reset_idle", bad_cnt, 0);
    checkOutput("no_resumed_frame", frames_seen, frames_before);

    #2 rst = 1'b0;
    val  = 1'b1;
    bits = 8'h5A;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rel = cycle_cnt;
    applyStimulus(8'h5A, 1, a);
    checkOutput("accept_after_release", a, rel + 1);
    waitIdle(200);
    checkOutput("release_frame", frames_seen, frames_before + 1);

    $display("[TB] loopback 0x00..0xFF");
    frames_seen = 0;
    for (int i = 0; i < 256; i++) applyStimulus(i[7:0], 200, a);
    waitIdle(1000);
    checkOutput("loop_frames", frames_seen, 256);
    checkOutput("loop_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs232_tx_ctrl.md
RS232_TX_CTRL -- requirements
Module: rs232_tx_ctrl

Interface
REQ-001 SHALL have parameter BAUD, default clock/4 under MODEL_TECH else 9600, meaning the line bit rate.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the byte buffer depth (power of two, >=2).
REQ-003 SHALL have parameter NOISY, default 0, meaning nonzero makes the simulation print each byte as its start bit is driven.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port val  input  1  byte on bits is offered.
REQ-007 SHALL have port bits  input  8  byte to transmit.
REQ-008 SHALL have port rdy  output  1  buffer can accept a byte this cycle.
REQ-009 SHALL have port busy  output  1  buffer non-empty or frame in progress.
REQ-010 SHALL have port TxD  output  1  serial line, idle high, registered.

Function
REQ-011 SHALL derive CLOCKS_PER_BIT = 1000000000*CLKMUL/(BAUD*CLKDIV*CLKIN_PERIOD) as a localparam.
REQ-012 SHALL accept a byte into the FIFO on every rising edge where val && rdy; val without rdy is ignored and bits need not be held.
REQ-013 SHALL drive rdy = !full, combinationally from the FIFO count; rdy is not a function of val.
REQ-014 SHALL frame each byte 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each exactly CLOCKS_PER_BIT cycles, frame exactly 10*CLOCKS_PER_BIT cycles.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP: IDLE->START when FIFO non-empty (pop same edge, load shift register); START->DATA after one bit time; DATA->STOP after the 8th bit time; STOP->START if FIFO non-empty at stop-bit end (pop), else STOP->IDLE.
REQ-016 SHALL time bits with counter cnt of width log2x(CLOCKS_PER_BIT), reset to 0 on every state entry, wrapping at CLOCKS_PER_BIT-1; bit index counter 3 bits.
REQ-017 SHALL, with idle FSM and empty FIFO, drive TxD low from the second rising edge after the accepting edge (latency 2 cycles).
REQ-018 SHALL send back-to-back frames with no idle gap while the FIFO stays non-empty.
REQ-019 SHALL permit push and pop on the same edge; count unchanged, data order preserved.
REQ-020 SHALL never pop when empty and never push when full; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL hold busy high from the edge after acceptance until the FSM returns to IDLE with FIFO empty.
REQ-022 SHALL hold TxD high in IDLE and STOP.

Reset
REQ-023 SHALL, on rst low, immediately (asynchronously) set TxD=1, busy=0, FSM=IDLE, FIFO empty (rdy=1 once count cleared), counters 0.
REQ-024 SHALL truncate any frame in progress on reset; no partial frame resumes after release.
REQ-025 SHALL accept no byte while rst is low; first acceptance possible on first edge after release.

Structure
REQ-026 SHALL take CLKMUL, CLKDIV, CLKIN_PERIOD from libconf and log2x from libstd; no new package types required.
REQ-027 SHALL place the FSM state enum in libstd only if shared; otherwise local to the module.
REQ-028 SHALL implement the buffer as sub-module rs232_tx_fifo (8-bit data, FIFO_DEPTH, push/pop/full/empty, async active-low reset).

Verification (CLOCKS_PER_BIT=4)
REQ-029 SHALL check: single byte 0x55 accepted at edge E -> TxD low from E+2 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), stop 1, busy falls at frame end (40 cycles after TxD fell).
REQ-030 SHALL check: val held with bytes 0x00..0x05 -> rdy low after 4 buffered while one in flight, six contiguous frames, no gap, order preserved.
REQ-031 SHALL check: push while stop bit of last frame ends and FIFO had 1 entry -> simultaneous push/pop, count unchanged, next frame starts immediately.
REQ-032 SHALL check: rst low mid-DATA of 0xA3 -> TxD=1 same cycle without clock, busy=0, rdy=1; after release line stays idle.
REQ-033 SHALL check: loopback into the existing RS-232 receiver at matching BAUD, 256 bytes 0x00..0xFF -> all received in order, receiver error never asserted.
REQ-034 SHALL check: val pulsed with rdy low -> byte discarded, no extra frame emitted.
